extram_sram_ctrl: RTL and testbench
===================================

Name: extram_sram_ctrl

Overview:
- Responder for the SoC external-RAM bus (extram_valid/ready/wstrb/addr/wdata/rdata) driven by the CPU side for window 0x0400_0000–0x0407_FFFC.
- Services each 32-bit request as two 16-bit accesses to an asynchronous 256K x16 SRAM, with a programmable wait-state count.
- Sits at top level beside the SoC; SRAM pins go straight to the board.

Parameters:
- WAIT_CYCLES, 1, extra strobe cycles per half-access (strobe length = WAIT_CYCLES+1), range 0..15.
- ADDR_BITS, 18, SRAM halfword address width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- extram_valid  in  1  request valid, held until ready
- extram_ready  out  1  one-cycle completion pulse
- extram_wstrb  in  4  byte strobes; 0 = read
- extram_addr  in  32  byte address; bits [18:2] = word index
- extram_wdata  in  32  write data
- extram_rdata  out  32  read data, valid with ready, held until next read completes
- sram_addr  out  ADDR_BITS  halfword address = {addr[18:2], half}
- sram_dq_o  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_i  in  16  read data from pad
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM controls

Behaviour:
- Reset (async, immediate): extram_ready=0, extram_rdata=0, all *_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, FSM=IDLE, half=0.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE; the half flag selects low (0, bytes 1:0) or high (1, bytes 3:2).
- IDLE: on extram_valid, latch addr/wdata/wstrb.
  - Read: start half 0.
  - Write: start at the lowest half with a nonzero strobe pair; a write with only wstrb[3:2] set skips half 0.
  - Then go to SETUP.
- SETUP (1 cycle): ce_n=0, sram_addr driven, oe_n=we_n=1.
  - Write: dq_o = selected wdata halfword, dq_oe=1, lb_n=!wstrb[2*half], ub_n=!wstrb[2*half+1].
  - Read: lb_n=ub_n=0.
- STROBE (WAIT_CYCLES+1 cycles, down-counter): read oe_n=0; write we_n=0. Read captures sram_dq_i into rdata[16*half+:16] on the last STROBE cycle.
- HOLD (write only, 1 cycle): we_n=1, address/data/dq_oe unchanged.
- After STROBE (read) or HOLD (write):
  - If the next half is needed (read: always after half 0; write: half 1 strobes nonzero), set half=1 and go to SETUP.
  - Else go to DONE.
- DONE (1 cycle): extram_ready=1 (registered), ce_n=1, dq_oe=0, then IDLE. Valid is low in the cycle after ready; IDLE may accept a new request in that next cycle.
- Latency (valid first seen in cycle 0, ready high in cycle N):
  - Read: N = 1 + 2*(WAIT_CYCLES+2).
  - Write: N = 1 + (WAIT_CYCLES+3) per active half.
- extram_rdata is updated only by reads; writes leave it unchanged.
- extram_wdata/addr/wstrb changes after acceptance are ignored (latched copy used).
- Reset asserted mid-access: strobes deassert asynchronously, in-flight write may be partial, no ready is issued.

Optional Feature:
- Macro EXTRAM_SRAM_RANGE_CHECK_EN.
- Defined: a request with addr[31:19] != 13'h0080 goes IDLE->DONE directly. Ready arrives in cycle 1, no SRAM pin toggles, reads return rdata=32'h0000_0000, writes are dropped.
- Undefined: addr[31:19] is ignored and every request accesses the SRAM.

Decomposition:
- Shared package extram_pkg: FSM state enum; constants EXTRAM_BASE=32'h0400_0000, EXTRAM_LAST=32'h0407_FFFC, SRAM_HALF_W=16.
- No sub-module: the wait counter and FSM stay in one module.

Test Plan:
- Reset, then read of 0x0400_0010 with SRAM model word 0x1234 at halfword 8, 0xABCD at halfword 9, WAIT_CYCLES=1 -> ready in cycle 7 exactly once, rdata=0xABCD1234, we_n never low.
- Write 0xDEADBEEF, wstrb=4'hF, addr 0x0400_0020 -> halfwords 16=0xBEEF and 17=0xDEAD written, ready in cycle 9, lb_n=ub_n=0 during both strobes.
- Write wstrb=4'b1000, wdata=0x5A000000 -> only half 1 accessed, ub_n=0, lb_n=1, byte becomes 0x5A and the other bytes are unchanged, ready in cycle 5.
- Back-to-back write then read to the same address with valid reasserted the cycle after ready -> second access starts correctly and reads back the written value.
- resetn pulsed low during the STROBE of half 1 -> we_n/oe_n/ce_n high in the same cycle, no ready, next request after reset completes normally.
- With EXTRAM_SRAM_RANGE_CHECK_EN, read of 0x0408_0000 -> ready in cycle 1, rdata=0, sram_ce_n stays 1.

Source files
------------

// File: rtl/extram_pkg.sv
// Shared types and constants for the external-RAM bus to async SRAM bridge.
package extram_pkg;

   localparam logic [31:0] EXTRAM_BASE = 32'h0400_0000;
   localparam logic [31:0] EXTRAM_LAST = 32'h0407_FFFC;
   localparam int          SRAM_HALF_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } extram_state_t;

   // True for any byte of a word inside the SRAM window.
   function automatic logic extram_in_window(input logic [31:0] addr);
      return (addr >= EXTRAM_BASE) && (addr <= (EXTRAM_LAST | 32'h0000_0003));
   endfunction

endpackage

// File: rtl/extram_sram_ctrl.sv
// External-RAM bus responder: each 32-bit request becomes two 16-bit async SRAM accesses.
// Define EXTRAM_SRAM_RANGE_CHECK_EN to complete out-of-window requests without touching the SRAM.
//
// state  | meaning
// IDLE   | waiting for extram_valid, latches the request
// SETUP  | address, lanes and write data set up, strobes inactive
// STROBE | oe_n (read) or we_n (write) low for WAIT_CYCLES+1 cycles
// HOLD   | write only: we_n released, address/data held one cycle
// DONE   | extram_ready pulse, SRAM deselected
module extram_sram_ctrl
   import extram_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_BITS   = 18
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   extram_valid,
   output logic                   extram_ready,
   input  logic [3:0]             extram_wstrb,
   input  logic [31:0]            extram_addr,
   input  logic [31:0]            extram_wdata,
   output logic [31:0]            extram_rdata,
   output logic [ADDR_BITS-1:0]   sram_addr,
   output logic [SRAM_HALF_W-1:0] sram_dq_o,
   output logic                   sram_dq_oe,
   input  logic [SRAM_HALF_W-1:0] sram_dq_i,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n,
   output logic                   sram_lb_n,
   output logic                   sram_ub_n
);

   localparam int WORD_BITS = ADDR_BITS - 1;

   extram_state_t          state, state_nxt;
   logic                   half, half_nxt;
   logic [3:0]             wcnt, wcnt_nxt;
   logic [WORD_BITS-1:0]   req_word, req_word_nxt;
   logic [31:0]            req_wdata, req_wdata_nxt;
   logic [3:0]             req_wstrb, req_wstrb_nxt;
   logic [31:0]            rdata_nxt;
   logic                   ready_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt, lb_n_nxt, ub_n_nxt, dq_oe_nxt;
   logic [ADDR_BITS-1:0]   addr_nxt;
   logic [SRAM_HALF_W-1:0] dq_o_nxt;
   logic                   in_range;
   logic                   req_rd, req_rd_nxt;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^{extram_addr[31:ADDR_BITS+1], extram_addr[1:0]};

`ifdef EXTRAM_SRAM_RANGE_CHECK_EN
   assign in_range = extram_in_window(extram_addr);
`else
   assign in_range = 1'b1;
`endif

   assign req_rd     = (req_wstrb == 4'h0);
   assign req_rd_nxt = (req_wstrb_nxt == 4'h0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         half         <= 1'b0;
         wcnt         <= 4'd0;
         req_word     <= '0;
         req_wdata    <= '0;
         req_wstrb    <= '0;
         extram_ready <= 1'b0;
         extram_rdata <= '0;
         sram_addr    <= '0;
         sram_dq_o    <= '0;
         sram_dq_oe   <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_lb_n    <= 1'b1;
         sram_ub_n    <= 1'b1;
      end else begin
         state        <= state_nxt;
         half         <= half_nxt;
         wcnt         <= wcnt_nxt;
         req_word     <= req_word_nxt;
         req_wdata    <= req_wdata_nxt;
         req_wstrb    <= req_wstrb_nxt;
         extram_ready <= ready_nxt;
         extram_rdata <= rdata_nxt;
         sram_addr    <= addr_nxt;
         sram_dq_o    <= dq_o_nxt;
         sram_dq_oe   <= dq_oe_nxt;
         sram_ce_n    <= ce_n_nxt;
         sram_oe_n    <= oe_n_nxt;
         sram_we_n    <= we_n_nxt;
         sram_lb_n    <= lb_n_nxt;
         sram_ub_n    <= ub_n_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      half_nxt      = half;
      wcnt_nxt      = wcnt;
      req_word_nxt  = req_word;
      req_wdata_nxt = req_wdata;
      req_wstrb_nxt = req_wstrb;
      rdata_nxt     = extram_rdata;

      case (state)
         ST_IDLE: begin
            if (extram_valid) begin
               req_word_nxt  = extram_addr[ADDR_BITS:2];
               req_wdata_nxt = extram_wdata;
               req_wstrb_nxt = extram_wstrb;
               if (!in_range) begin
                  state_nxt = ST_DONE;
                  if (extram_wstrb == 4'h0) rdata_nxt = '0;
               end else begin
                  // A write touching only the upper bytes starts directly on half 1.
                  half_nxt  = (extram_wstrb[1:0] == 2'b00) && (extram_wstrb[3:2] != 2'b00);
                  state_nxt = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            state_nxt = ST_STROBE;
            wcnt_nxt  = 4'(WAIT_CYCLES);
         end
         ST_STROBE: begin
            if (wcnt != 4'd0) begin
               wcnt_nxt = wcnt - 4'd1;
            end else if (req_rd) begin
               if (half) rdata_nxt[31:16] = sram_dq_i;
               else      rdata_nxt[15:0]  = sram_dq_i;
               if (!half) begin
                  half_nxt  = 1'b1;
                  state_nxt = ST_SETUP;
               end else begin
                  state_nxt = ST_DONE;
               end
            end else begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!half && (req_wstrb[3:2] != 2'b00)) begin
               half_nxt  = 1'b1;
               state_nxt = ST_SETUP;
            end else begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            half_nxt  = 1'b0;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Pin values are decoded from the state being entered so every pin is a flop.
      ready_nxt = 1'b0;
      ce_n_nxt  = 1'b1;
      oe_n_nxt  = 1'b1;
      we_n_nxt  = 1'b1;
      lb_n_nxt  = 1'b1;
      ub_n_nxt  = 1'b1;
      dq_oe_nxt = 1'b0;
      addr_nxt  = sram_addr;
      dq_o_nxt  = sram_dq_o;

      if ((state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD)) begin
         ce_n_nxt = 1'b0;
         addr_nxt = {req_word_nxt, half_nxt};
         if (req_rd_nxt) begin
            lb_n_nxt = 1'b0;
            ub_n_nxt = 1'b0;
         end else begin
            dq_o_nxt  = half_nxt ? req_wdata_nxt[31:16] : req_wdata_nxt[15:0];
            dq_oe_nxt = 1'b1;
            lb_n_nxt  = !req_wstrb_nxt[{half_nxt, 1'b0}];
            ub_n_nxt  = !req_wstrb_nxt[{half_nxt, 1'b1}];
         end
         if (state_nxt == ST_STROBE) begin
            if (req_rd_nxt) oe_n_nxt = 1'b0;
            else            we_n_nxt = 1'b0;
         end
      end

      if (state_nxt == ST_DONE) ready_nxt = 1'b1;
   end

endmodule

// File: tb/tb_extram_sram_ctrl.sv
// Bench for extram_sram_ctrl: SRAM array model, reference memory and per-cycle pin/latency checks.
module tb_extram_sram_ctrl;

   localparam int WC = 1;
   localparam int AB = 18;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        extram_valid;
   logic        extram_ready;
   logic [3:0]  extram_wstrb;
   logic [31:0] extram_addr;
   logic [31:0] extram_wdata;
   logic [31:0] extram_rdata;
   logic [AB-1:0] sram_addr;
   logic [15:0] sram_dq_o;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_i;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

   extram_sram_ctrl #(.WAIT_CYCLES(WC), .ADDR_BITS(AB)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .extram_valid (extram_valid),
      .extram_ready (extram_ready),
      .extram_wstrb (extram_wstrb),
      .extram_addr  (extram_addr),
      .extram_wdata (extram_wdata),
      .extram_rdata (extram_rdata),
      .sram_addr    (sram_addr),
      .sram_dq_o    (sram_dq_o),
      .sram_dq_oe   (sram_dq_oe),
      .sram_dq_i    (sram_dq_i),
      .sram_ce_n    (sram_ce_n),
      .sram_oe_n    (sram_oe_n),
      .sram_we_n    (sram_we_n),
      .sram_lb_n    (sram_lb_n),
      .sram_ub_n    (sram_ub_n)
   );

   always #5 clk = ~clk;

   logic [15:0] mem     [0:(1<<AB)-1];
   logic [15:0] ref_mem [0:(1<<AB)-1];

   int total = 0;
   int bad   = 0;

   // Expected-transaction state shared by the driver and the compare process
   logic        busy = 1'b0;
   int          cyc;
   int          exp_n;
   int          halves;
   int          ready_cyc;
   int          strobe_cnt;
   logic [1:0]  exp_mask;
   logic [1:0]  seen_mask;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_wstrb;
   logic        cur_rd;
   logic [31:0] exp_rdata;
   logic [31:0] model_rdata = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic in_win(input logic [31:0] a);
`ifdef EXTRAM_SRAM_RANGE_CHECK_EN
      return a[31:19] == 13'h0080;
`else
      return 1'b1;
`endif
   endfunction

   // Asynchronous SRAM: read data while selected and output-enabled, byte-lane writes while we_n low
   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hF00F;

   always @(negedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq_oe ? sram_dq_o[7:0]  : 8'hFF;
         if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq_oe ? sram_dq_o[15:8] : 8'hFF;
      end
   end

   // Compare process: runs every cycle, cycle 0 is the first cycle valid is seen
   always @(negedge clk) begin
      logic [AB-2:0] w;
      if (busy) begin
         w = cur_addr[AB:2];
         chk("ready_timing", {31'h0, extram_ready}, {31'h0, (cyc == exp_n)});
         if (extram_ready) ready_cyc = cyc;
         if (cur_rd) chk("we_n_during_read", {31'h0, sram_we_n}, 32'h1);
         else        chk("oe_n_during_write", {31'h0, sram_oe_n}, 32'h1);
         if (!sram_ce_n) chk("sram_word", {15'h0, sram_addr[AB-1:1]}, {15'h0, w});
         if (!sram_we_n || !sram_oe_n) begin
            strobe_cnt++;
            seen_mask[sram_addr[0]] = 1'b1;
            if (!sram_we_n) begin
               chk("lb_n_write", {31'h0, sram_lb_n}, {31'h0, !cur_wstrb[sram_addr[0] ? 2 : 0]});
               chk("ub_n_write", {31'h0, sram_ub_n}, {31'h0, !cur_wstrb[sram_addr[0] ? 3 : 1]});
               chk("dq_o_write", {16'h0, sram_dq_o},
                   {16'h0, (sram_addr[0] ? cur_wdata[31:16] : cur_wdata[15:0])});
               chk("dq_oe_write", {31'h0, sram_dq_oe}, 32'h1);
            end else begin
               chk("lanes_read", {30'h0, sram_ub_n, sram_lb_n}, 32'h0);
               chk("dq_oe_read", {31'h0, sram_dq_oe}, 32'h0);
            end
         end
         if (!cur_rd) chk("rdata_kept_on_write", extram_rdata, model_rdata);
         if (cyc == exp_n) begin
            chk("strobe_cycles", strobe_cnt, halves * (WC + 1));
            chk("halves_visited", {30'h0, seen_mask}, {30'h0, exp_mask});
            if (cur_rd) model_rdata = exp_rdata;
            chk("rdata_at_ready", extram_rdata, model_rdata);
            if (!cur_rd) begin
               chk("mem_lo", {16'h0, mem[{w, 1'b0}]}, {16'h0, ref_mem[{w, 1'b0}]});
               chk("mem_hi", {16'h0, mem[{w, 1'b1}]}, {16'h0, ref_mem[{w, 1'b1}]});
            end
            busy = 1'b0;
         end
         cyc++;
      end else begin
         chk("idle_ready", {31'h0, extram_ready}, 32'h0);
         chk("idle_ce_n", {31'h0, sram_ce_n}, 32'h1);
         chk("idle_rdata", extram_rdata, model_rdata);
      end
   end

   // Called at #1 after a rising edge; drives the request and records what must happen
   task automatic start_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      logic [AB-2:0] w;
      logic          inr;
      w = a[AB:2];
      inr = in_win(a);
      extram_addr  = a;
      extram_wstrb = s;
      extram_wdata = d;
      extram_valid = 1'b1;
      cur_addr  = a;
      cur_wstrb = s;
      cur_wdata = d;
      cur_rd    = (s == 4'h0);
      if (!inr)        exp_mask = 2'b00;
      else if (cur_rd) exp_mask = 2'b11;
      else             exp_mask = {|s[3:2], |s[1:0]};
      halves = int'(exp_mask[0]) + int'(exp_mask[1]);
      if (!inr) begin
         exp_n = 1;
         exp_rdata = cur_rd ? 32'h0 : model_rdata;
      end else if (cur_rd) begin
         exp_n = 1 + 2 * (WC + 2);
         exp_rdata = {ref_mem[{w, 1'b1}], ref_mem[{w, 1'b0}]};
      end else begin
         exp_n = 1 + (WC + 3) * halves;
         exp_rdata = model_rdata;
         if (s[0]) ref_mem[{w, 1'b0}][7:0]  = d[7:0];
         if (s[1]) ref_mem[{w, 1'b0}][15:8] = d[15:8];
         if (s[2]) ref_mem[{w, 1'b1}][7:0]  = d[23:16];
         if (s[3]) ref_mem[{w, 1'b1}][15:8] = d[31:24];
      end
      strobe_cnt = 0;
      seen_mask  = 2'b00;
      ready_cyc  = -1;
      cyc        = 0;
      busy       = 1'b1;
      @(posedge clk);
      #1;
      // Request fields are don't-care once accepted
      extram_addr  = $urandom;
      extram_wdata = $urandom;
      extram_wstrb = 4'($urandom);
   endtask

   task automatic finish_req(output int lat);
      int n;
      n = 0;
      while (busy && n < 64) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("req_timeout", {31'h0, busy}, 32'h0);
      busy = 1'b0;
      lat = ready_cyc;
      @(posedge clk);
      #1;
      extram_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [31:0] a;
      logic [3:0]  s;
      extram_valid = 1'b0;
      extram_addr  = '0;
      extram_wdata = '0;
      extram_wstrb = '0;
      for (int i = 0; i < (1 << AB); i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[8] = 16'h1234; ref_mem[8] = 16'h1234;
      mem[9] = 16'hABCD; ref_mem[9] = 16'hABCD;

      #1 resetn = 1'b0;
      #2;
      chk("rst_ready", {31'h0, extram_ready}, 32'h0);
      chk("rst_rdata", extram_rdata, 32'h0);
      chk("rst_addr", {14'h0, sram_addr}, 32'h0);
      chk("rst_dq_o", {16'h0, sram_dq_o}, 32'h0);
      chk("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
      chk("rst_ctl_n", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;

      start_req(32'h0400_0010, 4'h0, 32'h0);
      finish_req(lat);
      chk("t1_latency", lat, 7);
      chk("t1_rdata", extram_rdata, 32'hABCD_1234);

      start_req(32'h0400_0020, 4'hF, 32'hDEAD_BEEF);
      finish_req(lat);
      chk("t2_latency", lat, 9);
      chk("t2_mem16", {16'h0, mem[16]}, 32'hBEEF);
      chk("t2_mem17", {16'h0, mem[17]}, 32'hDEAD);

      start_req(32'h0400_0020, 4'b1000, 32'h5A00_0000);
      finish_req(lat);
      chk("t3_latency", lat, 5);
      chk("t3_mem16", {16'h0, mem[16]}, 32'hBEEF);
      chk("t3_mem17", {16'h0, mem[17]}, 32'h5AAD);

      start_req(32'h0400_0030, 4'hF, 32'h1357_9BDF);
      finish_req(lat);
      start_req(32'h0400_0030, 4'h0, 32'h0);
      finish_req(lat);
      chk("t4_latency", lat, 7);
      chk("t4_rdata", extram_rdata, 32'h1357_9BDF);

      // Reset during the half-1 strobe of a full write (cycles 6-7 with one wait state)
      start_req(32'h0400_0040, 4'hF, 32'hCAFE_F00D);
      repeat (5) @(posedge clk);
      #2;
      resetn = 1'b0;
      busy = 1'b0;
      model_rdata = 32'h0;
      extram_valid = 1'b0;
      #1;
      chk("t5_ctl_n", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
      chk("t5_ready", {31'h0, extram_ready}, 32'h0);
      chk("t5_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
      ref_mem[32] = mem[32];
      ref_mem[33] = mem[33];
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      start_req(32'h0400_0040, 4'h0, 32'h0);
      finish_req(lat);
      chk("t5_after_latency", lat, 7);

`ifdef EXTRAM_SRAM_RANGE_CHECK_EN
      start_req(32'h0408_0000, 4'h0, 32'h0);
      finish_req(lat);
      chk("t6_latency", lat, 1);
      chk("t6_rdata", extram_rdata, 32'h0);
`else
      start_req(32'h0408_0010, 4'h0, 32'h0);
      finish_req(lat);
      chk("t6_alias_latency", lat, 7);
      chk("t6_alias_rdata", extram_rdata, 32'hABCD_1234);
`endif

      for (int i = 0; i < 120; i++) begin
         int g;
         if ($urandom_range(0, 1) == 0) a = 32'h0400_0000 | (32'($urandom_range(0, 31)) << 2);
         else                           a = 32'h0400_0000 | (32'($urandom_range(0, 32'h1FFFF)) << 2);
         if ($urandom_range(0, 7) == 0) a[31:19] = 13'($urandom);
         if ($urandom_range(0, 2) == 0) s = 4'h0;
         else                           s = 4'($urandom);
         g = $urandom_range(0, 3);
         if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
         end
         start_req(a, s, $urandom);
         finish_req(lat);
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
